// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state and requester IDs for the RAM access arbiter
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/ram_slot_timer.sv
// ram_slot_timer: slot phase counter with start/end strobes and read-latency slot down-counter
module ram_slot_timer #(
  parameter int DIV    = 4,
  parameter int RD_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_slot_start,
  output logic o_slot_end,
  output logic o_expire
);
  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(RD_LAT + 1);
  logic [PW-1:0] r_ph;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph  <= '0;
      r_cnt <= '0;
    end else begin
      r_ph  <= o_slot_end ? '0 : r_ph + 1'b1;
      r_cnt <= i_load ? CW'(RD_LAT) : (o_slot_end && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    end
  end
  assign o_slot_start = r_ph == '0;
  assign o_slot_end   = r_ph == PW'(DIV - 1);
  // the counter hits zero at this slot end
  assign o_expire     = o_slot_end && r_cnt == CW'(1);
endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: two-requester round-robin sequencer for a slow-clocked single-port RAM
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 4,
  parameter int DIV    = 4,
  parameter int RD_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  state_t        r_state, w_next;
  logic          r_last, r_we, r_rvalid, r_a_ack_d, r_b_ack_d;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_a_rdata, r_b_rdata;
  logic          w_slot_start, w_slot_end, w_expire, w_load, w_rd_done, w_wr_ack;
  logic          w_elig_a, w_elig_b, w_gnt, w_gnt_b, w_issue, w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  ram_slot_timer #(.DIV(DIV), .RD_LAT(RD_LAT)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .o_slot_start (w_slot_start),
    .o_slot_end   (w_slot_end),
    .o_expire     (w_expire)
  );

  // a requester is masked in its ack cycle and the one after
  assign w_elig_a  = a_req & ~a_ack & ~r_a_ack_d;
  assign w_elig_b  = b_req & ~b_ack & ~r_b_ack_d;
  assign w_gnt     = r_state == IDLE && w_slot_start && (w_elig_a || w_elig_b);
  assign w_gnt_b   = w_elig_b && (!w_elig_a || r_last == REQ_A);
  assign w_load    = r_state == ISSUE && w_slot_end && !r_we;
  assign w_wr_ack  = r_state == ISSUE && w_slot_end && r_we;
  assign w_rd_done = r_state == WAIT_RD && w_expire;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state == IDLE    ? (w_gnt ? ISSUE : IDLE)
           : r_state == ISSUE   ? (w_slot_end ? (r_we ? IDLE : WAIT_RD) : ISSUE)
           : r_state == WAIT_RD ? (w_rd_done ? IDLE : WAIT_RD)
           : IDLE;
  end

  // the grant cycle drives the RAM straight from the winning request
  always_comb begin
    w_issue  = r_state == ISSUE || w_gnt;
    w_we     = w_gnt ? (w_gnt_b ? b_we : a_we) : r_we;
    w_addr   = w_gnt ? (w_gnt_b ? b_addr : a_addr) : r_addr;
    w_wdata  = w_gnt ? (w_gnt_b ? b_wdata : a_wdata) : r_wdata;
    ram_en   = w_issue;
    ram_we   = w_issue & w_we;
    ram_addr = w_issue ? w_addr : '0;
    ram_din  = (w_issue && w_we) ? w_wdata : '0;
    a_ack    = (w_wr_ack || r_rvalid) && r_last == REQ_A;
    b_ack    = (w_wr_ack || r_rvalid) && r_last == REQ_B;
    a_rvalid = r_rvalid && r_last == REQ_A;
    b_rvalid = r_rvalid && r_last == REQ_B;
    a_rdata  = r_a_rdata;
    b_rdata  = r_b_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last    <= REQ_B;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rvalid  <= 1'b0;
      r_a_ack_d <= 1'b0;
      r_b_ack_d <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_rvalid  <= w_rd_done;
      r_a_ack_d <= a_ack;
      r_b_ack_d <= b_ack;
      if (w_gnt) begin
        r_last  <= w_gnt_b ? REQ_B : REQ_A;
        r_we    <= w_we;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      if (w_rd_done && r_last == REQ_A) r_a_rdata <= ram_dout;
      if (w_rd_done && r_last == REQ_B) r_b_rdata <= ram_dout;
    end
  end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed stimulus with a slot-level reference model checked every cycle
module tb_ram_access_arbiter;
  localparam int DW = 16, AW = 4, DIV = 4, RD_LAT = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ack, a_rvalid, b_ack, b_rvalid, ram_en, ram_we;
  logic [DW-1:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  int n_chk = 0, n_err = 0, cyc = 0, ph_t = 0, slot_t = 0;

  ram_access_arbiter #(.DW(DW), .AW(AW), .DIV(DIV), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    ph_t   <= rst ? 0 : (ph_t == DIV - 1 ? 0 : ph_t + 1);
    slot_t <= rst ? 0 : slot_t + (ph_t == DIV - 1 ? 1 : 0);
  end

  // slow RAM: dout shows the addressed word RD_LAT slots after a read slot
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] pipe [RD_LAT];
  initial for (int i = 0; i < 16; i++) ram_mem[i] = '0;
  initial for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    if (ram_en && ram_we) ram_mem[ram_addr] <= ram_din;
    if (ph_t == DIV - 1) begin
      pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : '0;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign ram_dout = pipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // transaction-level model: one access at a time, timed by slot numbers
  bit m_busy = 0, m_own = 0, m_we = 0, m_last = 1, armed = 0;
  bit m_ackp [2] = '{0, 0};
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_rd [2] = '{16'h0, 16'h0};
  logic [DW-1:0] m_mem [16];
  int m_islot = 0;
  initial for (int i = 0; i < 16; i++) m_mem[i] = '0;

  task automatic model_step();
    logic e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [1:0] e_ack, e_rv;
    bit fin, ea, eb, g;
    e_en = 0; e_we = 0; e_addr = '0; e_din = '0; e_ack = '0; e_rv = '0; fin = 0;
    if (m_busy && slot_t == m_islot) begin
      e_en = 1; e_we = m_we; e_addr = m_addr; e_din = m_we ? m_wd : '0;
      if (m_we && ph_t == DIV - 1) begin
        e_ack[m_own] = 1; fin = 1; m_mem[m_addr] = m_wd;
      end
    end
    if (m_busy && !m_we && slot_t == m_islot + RD_LAT + 1 && ph_t == 0) begin
      e_ack[m_own] = 1; e_rv[m_own] = 1; m_rd[m_own] = m_mem[m_addr]; fin = 1;
    end
    if (ph_t == 0 && (!m_busy || fin)) begin
      ea = a_req && !e_ack[0] && !m_ackp[0];
      eb = b_req && !e_ack[1] && !m_ackp[1];
      if (ea || eb) begin
        g = eb && (!ea || !m_last);
        m_own = g; m_last = g; m_busy = 1; fin = 0; m_islot = slot_t;
        m_we = g ? b_we : a_we; m_addr = g ? b_addr : a_addr; m_wd = g ? b_wdata : a_wdata;
        e_en = 1; e_we = m_we; e_addr = m_addr; e_din = m_we ? m_wd : '0;
      end
    end
    if (fin) m_busy = 0;
    if (armed) begin
      chk("ram_en", 32'(ram_en), 32'(e_en));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("ram_din", 32'(ram_din), 32'(e_din));
      chk("a_ack", 32'(a_ack), 32'(e_ack[0]));
      chk("b_ack", 32'(b_ack), 32'(e_ack[1]));
      chk("a_rvalid", 32'(a_rvalid), 32'(e_rv[0]));
      chk("b_rvalid", 32'(b_rvalid), 32'(e_rv[1]));
      chk("a_rdata", 32'(a_rdata), 32'(m_rd[0]));
      chk("b_rdata", 32'(b_rdata), 32'(m_rd[1]));
    end
    if (rst) begin
      m_busy = 0; m_last = 1; m_ackp = '{0, 0}; m_rd = '{16'h0, 16'h0}; armed = 1;
    end else begin
      m_ackp[0] = e_ack[0]; m_ackp[1] = e_ack[1];
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic go_ph(input int p);
    do begin @(posedge clk); #1; end while (ph_t != p);
  endtask

  task automatic wait_sig(input string nm, input int sel, input int bound, output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      s = sel == 0 ? ram_en : sel == 1 ? a_ack : sel == 2 ? b_ack : sel == 3 ? a_rvalid : b_rvalid;
    end while (!s && n < bound);
    chk({nm, "_seen"}, 32'(s), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t_a, cnt;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_a_rdata", 32'(a_rdata), 32'd0);
    // 1: A writes 5 <- 0x1234, request raised at ph 1
    go_ph(1);
    a_req = 1; a_we = 1; a_addr = 5; a_wdata = 16'h1234;
    wait_sig("t1_en", 0, 12, n);
    chk("t1_en_delay", 32'(n), 32'd4);
    chk("t1_addr", 32'(ram_addr), 32'd5);
    chk("t1_din", 32'(ram_din), 32'h1234);
    wait_sig("t1_ack", 1, 12, n);
    chk("t1_ack_delay", 32'(n), 32'd3);
    @(posedge clk); #1 a_req = 0;
    // 2: A reads 5
    go_ph(2);
    a_req = 1; a_we = 0; a_addr = 5;
    wait_sig("t2_en", 0, 12, n);
    chk("t2_we", 32'(ram_we), 32'd0);
    wait_sig("t2_rv", 3, 40, n);
    chk("t2_latency", 32'(n), 32'd16);
    chk("t2_rdata", 32'(a_rdata), 32'h1234);
    chk("t2_ack", 32'(a_ack), 32'd1);
    chk("t2_b_rvalid", 32'(b_rvalid), 32'd0);
    @(posedge clk); #1 a_req = 0;
    // 3: both write from reset, A then re-requests
    rst = 1;
    @(posedge clk); #1 rst = 0;
    a_req = 1; a_we = 1; a_addr = 1; a_wdata = 16'h0A0A;
    b_req = 1; b_we = 1; b_addr = 2; b_wdata = 16'h0B0B;
    wait_sig("t3_a_ack", 1, 12, n);
    chk("t3_a_slot", 32'(n), 32'd4);
    @(posedge clk); #1 a_addr = 3; a_wdata = 16'h0303;
    wait_sig("t3_b_ack", 2, 12, n);
    chk("t3_b_slot", 32'(n), 32'd4);
    @(posedge clk); #1 b_req = 0;
    wait_sig("t3_a2_ack", 1, 12, n);
    chk("t3_a2_slot", 32'(n), 32'd4);
    @(posedge clk); #1 a_req = 0;
    // 4: A reads 2 while B write to 7 waits
    go_ph(1);
    a_req = 1; a_we = 0; a_addr = 2;
    wait_sig("t4_en", 0, 12, n);
    chk("t4_a_addr", 32'(ram_addr), 32'd2);
    t_a = cyc;
    @(posedge clk); #1 b_req = 1; b_we = 1; b_addr = 7; b_wdata = 16'h0707;
    wait_sig("t4_rv", 3, 40, n);
    chk("t4_rdata", 32'(a_rdata), 32'h0B0B);
    chk("t4_b_en", 32'(ram_en), 32'd1);
    chk("t4_b_addr", 32'(ram_addr), 32'd7);
    chk("t4_b_gap", 32'(cyc - t_a), 32'd16);
    @(posedge clk); #1 a_req = 0;
    wait_sig("t4_b_ack", 2, 12, n);
    chk("t4_b_ack_delay", 32'(n), 32'd3);
    @(posedge clk); #1 b_req = 0;
    // 5: reset during a B read wait
    go_ph(1);
    b_req = 1; b_we = 0; b_addr = 7;
    wait_sig("t5_en", 0, 12, n);
    repeat (6) @(posedge clk);
    #1 rst = 1; b_req = 0;
    @(posedge clk); #1 rst = 0;
    cnt = 0;
    repeat (24) begin
      @(negedge clk);
      cnt += 32'(ram_en | ram_we | (|ram_addr) | (|ram_din) | b_ack | b_rvalid | a_ack);
    end
    chk("t5_quiet", 32'(cnt), 32'd0);
    chk("t5_b_rdata", 32'(b_rdata), 32'd0);
    go_ph(1);
    a_req = 1; a_we = 1; a_addr = 8; a_wdata = 16'h0808;
    b_req = 1; b_we = 1; b_addr = 9; b_wdata = 16'h0909;
    wait_sig("t5_en2", 0, 12, n);
    chk("t5_a_first", 32'(ram_addr), 32'd8);
    wait_sig("t5_a_ack", 1, 12, n);
    chk("t5_a_ack_delay", 32'(n), 32'd3);
    @(posedge clk); #1 a_req = 0;
    wait_sig("t5_b_ack", 2, 12, n);
    chk("t5_b_ack_delay", 32'(n), 32'd4);
    @(posedge clk); #1 b_req = 0;
    go_ph(3);
    b_req = 1; b_we = 0; b_addr = 9;
    wait_sig("t5_b_rv", 4, 40, n);
    chk("t5_b_rdata2", 32'(b_rdata), 32'h0909);
    chk("t5_a_rdata_kept", 32'(a_rdata), 32'd0);
    @(posedge clk); #1 b_req = 0;
    // 6: idle for 40 clocks
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      cnt += 32'(ram_en | a_ack | b_ack | a_rvalid | b_rvalid);
    end
    chk("t6_idle", 32'(cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
